// File: rtl/fu_div_rem_iter_pkg.sv
// Shared M-extension encodings and divider FSM state type for the iterative divide/remainder unit.
package fu_div_rem_iter_pkg;

  localparam logic [2:0] mult_div_f3_mul    = 3'b000;
  localparam logic [2:0] mult_div_f3_mulh   = 3'b001;
  localparam logic [2:0] mult_div_f3_mulhsu = 3'b010;
  localparam logic [2:0] mult_div_f3_mulhu  = 3'b011;
  localparam logic [2:0] mult_div_f3_div    = 3'b100;
  localparam logic [2:0] mult_div_f3_divu   = 3'b101;
  localparam logic [2:0] mult_div_f3_rem    = 3'b110;
  localparam logic [2:0] mult_div_f3_remu   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  function automatic logic f3_is_div_rem(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic f3_is_signed(input logic [2:0] f3);
    return (f3 == mult_div_f3_div) || (f3 == mult_div_f3_rem);
  endfunction

  function automatic logic f3_is_rem(input logic [2:0] f3);
    return (f3 == mult_div_f3_rem) || (f3 == mult_div_f3_remu);
  endfunction

endpackage

// File: rtl/fu_div_rem_iter_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   pr_in,
  input  logic            bit_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   pr_out,
  output logic            q_bit
);

  logic [XLEN:0] shifted;
  logic          fits;

  // Between steps the partial remainder is below the divisor, so its top bit is
  // always clear; folding it into the compare keeps the full XLEN+1 bits meaningful.
  always_comb begin
    shifted = {pr_in[XLEN-1:0], bit_in};
    fits    = pr_in[XLEN] || (shifted >= {1'b0, divisor});
    pr_out  = fits ? (shifted - {1'b0, divisor}) : shifted;
    q_bit   = fits;
  end

endmodule

// File: rtl/fu_div_rem_iter.sv
// Iterative radix-2^BITS_PER_CYCLE restoring divide/remainder unit for RV32M/RV64M with
// valid/ready handshakes, tag pass-through and flush.
module fu_div_rem_iter
  import fu_div_rem_iter_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int PHYS_REG_BITS  = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               funct3,
  input  logic [XLEN-1:0]          rs1_v,
  input  logic [XLEN-1:0]          rs2_v,
  input  logic [PHYS_REG_BITS-1:0] req_tag,
  input  logic                     flush,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [XLEN-1:0]          rd_v,
  output logic [PHYS_REG_BITS-1:0] resp_tag
);

  localparam int DIV_ITERS = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W     = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;
  localparam logic [CNT_W-1:0]       LAST_ITER = CNT_W'(DIV_ITERS - 1);
  localparam logic [XLEN-1:0]        MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic signed [XLEN-1:0] ZERO_S    = '0;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

  div_state_t state, state_next;

  logic                   accept;
  logic                   special;
  logic                   last_iter;
  logic [2:0]             op_f3;
  logic                   op_signed;
  logic                   op_rem;
  logic signed [XLEN-1:0] dividend_s;
  logic signed [XLEN-1:0] divisor_s;
  logic [XLEN-1:0]        dividend_mag;
  logic [XLEN-1:0]        divisor_mag;
  logic                   div_by_zero;
  logic                   overflow;
  logic [XLEN-1:0]        special_res;
  logic [XLEN-1:0]        final_res;

  logic [CNT_W-1:0]       iter_cnt;
  logic [XLEN:0]          rem_r;
  logic [XLEN-1:0]        quo_r;
  logic [XLEN-1:0]        dsr_r;
  logic                   is_rem_r;
  logic                   q_neg_r;
  logic                   r_neg_r;

  logic [BITS_PER_CYCLE:0][XLEN:0]   pr_c;
  logic [BITS_PER_CYCLE:0][XLEN-1:0] qd_c;

  // Request decode: non-divide encodings fall back to divu so the unit always completes.
  always_comb begin
    op_f3        = f3_is_div_rem(funct3) ? funct3 : mult_div_f3_divu;
    op_signed    = f3_is_signed(op_f3);
    op_rem       = f3_is_rem(op_f3);
    dividend_s   = signed'(rs1_v);
    divisor_s    = signed'(rs2_v);
    dividend_mag = neg_if(rs1_v, op_signed && (dividend_s < ZERO_S));
    divisor_mag  = neg_if(rs2_v, op_signed && (divisor_s < ZERO_S));
    div_by_zero  = (rs2_v == '0);
    overflow     = op_signed && (rs1_v == MOST_NEG) && (rs2_v == '1);
    special      = div_by_zero || overflow;
    if (div_by_zero) begin
      special_res = op_rem ? rs1_v : '1;
    end else begin
      special_res = op_rem ? '0 : rs1_v;
    end
  end

  // Iteration datapath: BITS_PER_CYCLE restoring steps chained per cycle.
  assign pr_c[0] = rem_r;
  assign qd_c[0] = quo_r;

  for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
    logic q_bit;

    div_step #(
      .XLEN(XLEN)
    ) u_step (
      .pr_in  (pr_c[k]),
      .bit_in (qd_c[k][XLEN-1]),
      .divisor(dsr_r),
      .pr_out (pr_c[k+1]),
      .q_bit  (q_bit)
    );

    assign qd_c[k+1] = {qd_c[k][XLEN-2:0], q_bit};
  end

  always_comb begin
    last_iter = (iter_cnt == LAST_ITER);
    final_res = is_rem_r ? neg_if(pr_c[BITS_PER_CYCLE][XLEN-1:0], r_neg_r)
                         : neg_if(qd_c[BITS_PER_CYCLE], q_neg_r);
  end

  // Control FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Control FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = special ? DONE : CALC;
      end
      CALC: begin
        if (flush)          state_next = IDLE;
        else if (last_iter) state_next = DONE;
      end
      DONE: begin
        if (flush)           state_next = IDLE;
        else if (accept)     state_next = special ? DONE : CALC;
        else if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control FSM: outputs
  always_comb begin
    req_ready  = !flush && ((state == IDLE) || ((state == DONE) && resp_ready));
    resp_valid = (state == DONE);
  end

  assign accept = req_valid && req_ready;

  // Operand capture on accept, then one radix-2^BITS_PER_CYCLE iteration per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_cnt <= '0;
      rem_r    <= '0;
      quo_r    <= '0;
      dsr_r    <= '0;
      is_rem_r <= 1'b0;
      q_neg_r  <= 1'b0;
      r_neg_r  <= 1'b0;
      rd_v     <= '0;
      resp_tag <= '0;
    end else if (accept) begin
      iter_cnt <= '0;
      rem_r    <= '0;
      quo_r    <= dividend_mag;
      dsr_r    <= divisor_mag;
      is_rem_r <= op_rem;
      q_neg_r  <= op_signed && (rs1_v[XLEN-1] ^ rs2_v[XLEN-1]);
      r_neg_r  <= op_signed && rs1_v[XLEN-1];
      resp_tag <= req_tag;
      if (special) rd_v <= special_res;
    end else if ((state == CALC) && !flush) begin
      iter_cnt <= iter_cnt + CNT_W'(1);
      rem_r    <= pr_c[BITS_PER_CYCLE];
      quo_r    <= qd_c[BITS_PER_CYCLE];
      if (last_iter) rd_v <= final_res;
    end
  end

endmodule

// File: doc/fu_div_rem_iter.md
Name: fu_div_rem_iter

Overview:
- Parametrised iterative integer divide/remainder functional unit for the RV32M/RV64M execute stage. It succeeds the fixed-latency 33-bit DesignWare wrapper.
- Implements DIV/DIVU/REM/REMU natively as a radix-2^BITS_PER_CYCLE restoring divider, with ISA-exact divide-by-zero and overflow results.
- Uses valid/ready handshakes on both sides, passes a destination physical-register tag through, and squashes on branch flush.

Parameters:
- XLEN, 32, operand/result width; 32 or 64.
- BITS_PER_CYCLE, 1, quotient bits retired per cycle; 1, 2 or 4; must divide XLEN.
- PHYS_REG_BITS, 6, width of the destination tag.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- funct3  in  3  M-extension funct3; only div/divu/rem/remu are legal.
- rs1_v  in  XLEN  dividend.
- rs2_v  in  XLEN  divisor.
- req_tag  in  PHYS_REG_BITS  destination physical register.
- flush  in  1  global branch flush; kills any in-flight or pending op.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- rd_v  out  XLEN  quotient or remainder.
- resp_tag  out  PHYS_REG_BITS  tag of the result.

Behaviour:
- Reset values: state=IDLE, resp_valid=0, rd_v=0, resp_tag=0, req_ready=1 after release. Reset is asynchronous and may assert in any state; it aborts any operation.
- States:
  - IDLE -> CALC on accept, for a normal op.
  - IDLE -> DONE on accept, for a special case.
  - CALC -> DONE after N=XLEN/BITS_PER_CYCLE iterations.
  - DONE -> IDLE on resp_ready.
  - DONE -> CALC/DONE if resp_ready and a new accept occur in the same cycle (back-to-back).
- Accept: req_valid && req_ready.
  - req_ready = !flush && (state==IDLE || (state==DONE && resp_ready)).
- On accept, register funct3 and tag, plus |rs1| and |rs2| for signed ops (raw values for unsigned ops), the quotient sign (rs1[MSB]^rs2[MSB]) and the remainder sign (rs1[MSB]).
- Iteration: partial remainder is XLEN+1 bits. Each CALC cycle performs BITS_PER_CYCLE shift/compare/subtract steps.
- Latency, normal op: resp_valid is high exactly N cycles after the accept edge (32 for the defaults).
- Special cases complete in 1 cycle (resp_valid in the cycle after accept):
  - divisor==0: quotient = all-ones; remainder = rs1.
  - signed op with rs1 = most-negative and rs2 = -1: quotient = rs1; remainder = 0.
- Output: rd_v is the quotient for div/divu and the remainder for rem/remu. It is sign-corrected (two's-complement negation) for signed ops.
- rd_v and resp_tag are registered and held stable while resp_valid && !resp_ready.
- Flush: flush asserted in any state -> state=IDLE and resp_valid=0 on the next edge. A request presented in the flush cycle is not accepted. No result from a flushed op ever appears.
- Illegal funct3 (mul*) on accept: treated as divu, with the result discarded by the issuer. The unit does not hang.
- Flush and resp_ready high together in DONE: flush wins, and the result is considered consumed.

Decomposition:
- Shared rv32i_types package:
  - existing mult_div_f3_* encodings;
  - a new div_state_t enum {IDLE, CALC, DONE};
  - localparam DIV_ITERS = XLEN/BITS_PER_CYCLE, computed in the module from parameters.
- One sub-module, div_step: combinational single restoring step (partial remainder, dividend bit in -> new partial remainder, quotient bit). It is instantiated BITS_PER_CYCLE times in a chain.

Test Plan (XLEN=32, BITS_PER_CYCLE=1 unless stated):
1. div 20 / -3, tag 5 -> rd_v=0xFFFFFFFA, resp_tag=5, resp_valid exactly 32 cycles after accept. rem 20 / -3 -> rd_v=0x00000002. rem -20 / 3 -> 0xFFFFFFFE.
2. divu 0x80000000 / 0 -> 0xFFFFFFFF; remu 0x80000000 / 0 -> 0x80000000; div 7 / 0 -> 0xFFFFFFFF. Each resp_valid arrives 1 cycle after accept.
3. div 0x80000000 / 0xFFFFFFFF -> 0x80000000; rem with the same operands -> 0. divu 0xFFFFFFFF / 0x10 -> 0x0FFFFFFF, 32-cycle latency.
4. Backpressure: hold resp_ready=0 for 5 cycles in DONE -> rd_v/resp_tag stable and req_ready=0. Then raise resp_ready with req_valid=1 -> the new op is accepted in that same cycle and its result arrives 32 cycles later.
5. Flush 10 cycles into CALC -> resp_valid never asserts for that op. The next cycle req_ready=1; a new divu 100/7 returns 14 with the correct tag.
6. Assert rst_n=0 mid-CALC, away from a clock edge -> resp_valid=0 immediately. After release req_ready=1. Repeat test 1 with BITS_PER_CYCLE=4 -> latency 8, same results.
